first_counter_arbiter: RTL

Round-robin scheduler that shares one `first_counter` instance among `NREQ` requesters. Each requester asks for a counting job of a given length. The block grants one requester at a time and clears the shared counter. It then drives `enable` for exactly the requested number of cycles and reports completion with a one-cycle `done` pulse. It sits between the requester logic and the counter's `reset`/`enable` inputs, and observes `counter_out`/`overflow_out`.

---
 rtl/first_counter_pkg.sv | 19 +
 rtl/first_counter_arbiter_if.sv | 29 ++
 rtl/first_counter_arbiter_rr_pick.sv | 36 +++
 rtl/first_counter_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/first_counter_pkg.sv
// Shared types and constants for the first_counter round-robin arbiter.
// len_to_cycles maps a job length field to its enable-cycle count.
package first_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CW_DEFAULT = 4;

    // A zero length field stands for a full counter wrap.
    function automatic int len_to_cycles(input int len_val, input int cw);
        return (len_val == 0) ? (1 << cw) : len_val;
    endfunction

endpackage

// File: rtl/first_counter_arbiter_if.sv
// Requester and counter-side signals of the arbiter, bundled for port use.
// slave is the arbiter's view; master is the requester/counter side.
interface first_counter_arbiter_if
    import first_counter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               busy;
    logic               cnt_clr;
    logic               cnt_en;
    logic [CW-1:0]      cnt_val;
    logic               cnt_ovf;

    modport slave (
        input  req, len, cnt_val, cnt_ovf,
        output grant, done, err, busy, cnt_clr, cnt_en
    );

    modport master (
        output req, len, cnt_val, cnt_ovf,
        input  grant, done, err, busy, cnt_clr, cnt_en
    );
endinterface

// File: rtl/first_counter_arbiter_rr_pick.sv
// Combinational cyclic first-set search starting at rr_ptr.
// Returns the winner both as one-hot select and as an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [NREQ-1:0] sel,
    output logic [IW-1:0]   idx
);
    logic [IW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;

    // Candidate gi is the requester gi positions after the pointer.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_idx[gi] = IW'((32'(rr_ptr) + gi) % NREQ);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    assign valid = |cand_hit;

    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                idx = cand_idx[k];
            end
        end
        sel = '0;
        if (valid) begin
            sel[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/first_counter_arbiter.sv
// Round-robin scheduler sharing one first_counter among NREQ requesters.
// Each job: one clear cycle, tgt enable cycles, one done cycle.
module first_counter_arbiter
    import first_counter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    first_counter_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [CW-1:0]   tgt_reg;
    logic            ovf_seen_reg;

    logic            pick_valid;
    logic [NREQ-1:0] pick_sel;
    logic [IW-1:0]   pick_idx;
    logic [CW-1:0]   len_sel;
    logic [NREQ-1:0] owner_oh;
    logic            run_last;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .sel    (pick_sel),
        .idx    (pick_idx)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_sel[i]) begin
                len_sel = len_sel | bus.len[i*CW +: CW];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner_oh
        assign owner_oh[gi] = (owner_reg == IW'(gi));
    end

    // Counter reaches tgt on the edge leaving RUN; tgt=0 wraps to all-ones.
    assign run_last = (bus.cnt_val == tgt_reg - CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg    <= '0;
            tgt_reg      <= '0;
            ovf_seen_reg <= 1'b0;
            rr_ptr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_reg <= pick_idx;
                        tgt_reg   <= len_sel;
                    end
                end
                ST_CLR: begin
                    ovf_seen_reg <= 1'b0;
                end
                ST_RUN: begin
                    if (bus.cnt_ovf && (tgt_reg != '0)) begin
                        ovf_seen_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr_reg <= (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (pick_valid) state_next = ST_CLR;
            ST_CLR:  state_next = ST_RUN;
            ST_RUN:  if (run_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.grant   = (state_reg != ST_IDLE) ? owner_oh : '0;
        bus.done    = (state_reg == ST_DONE) ? owner_oh : '0;
        bus.err     = (state_reg == ST_DONE) && ovf_seen_reg;
        bus.busy    = (state_reg != ST_IDLE);
        bus.cnt_clr = (state_reg == ST_CLR);
        bus.cnt_en  = (state_reg == ST_RUN);
    end
endmodule
